// File: rtl/fifo_rd_stream_if.sv
// Bundle of FIFO read-side and downstream stream signals for fifo_rd_stream.
// The master view belongs to the consumer block; the slave view belongs to the FIFO and the downstream sink.
interface fifo_rd_stream_if #(
  parameter int DATASIZE = 8
);
  logic                fifo_empty_i;
  logic [DATASIZE-1:0] fifo_dout_i;
  logic                fifo_ren_o;
  logic                m_valid_o;
  logic                m_ready_i;
  logic [DATASIZE-1:0] m_data_o;
  logic                m_last_o;

  modport master (
    input  fifo_empty_i,
    input  fifo_dout_i,
    input  m_ready_i,
    output fifo_ren_o,
    output m_valid_o,
    output m_data_o,
    output m_last_o
  );

  modport slave (
    output fifo_empty_i,
    output fifo_dout_i,
    output m_ready_i,
    input  fifo_ren_o,
    input  m_valid_o,
    input  m_data_o,
    input  m_last_o
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// FIFO read-side consumer: reads custom_async_fifo into a 2-entry skid buffer and emits a framed valid/ready stream.
// Optional word/stall statistics counters are enabled by defining FIFO_RD_STATS_EN.
module fifo_rd_stream #(
  parameter int DATASIZE  = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                  rclk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  fifo_rd_stream_if.master      bus,
  output logic                  busy_o
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [31:0]           words_o,
  output logic [31:0]           stalls_o
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [7:0] LAST_CNT = 8'(BURST_LEN - 1);

  state_t              state;
  logic [1:0]          occ;
  logic                inflight;
  logic [7:0]          burst_cnt;
  logic [DATASIZE-1:0] data0;
  logic [DATASIZE-1:0] data1;
  logic                last0;
  logic                last1;

  logic                pop;
  logic                ren;
  logic                cap_last;
  logic [1:0]          credit;
  logic [1:0]          wr_idx;

  assign pop      = bus.m_valid_o && bus.m_ready_i;
  assign credit   = occ + {1'b0, inflight} - {1'b0, pop};
  assign ren      = (state == RUN) && !bus.fifo_empty_i && (credit < 2'd2);
  assign cap_last = (burst_cnt == LAST_CNT);
  // A capture lands behind whatever survives this cycle's pop.
  assign wr_idx   = occ - {1'b0, pop};

  assign bus.fifo_ren_o = ren;
  assign bus.m_valid_o  = (occ != 2'd0);
  assign bus.m_data_o   = data0;
  assign bus.m_last_o   = last0;
  assign busy_o         = (state != IDLE);

  always_ff @(posedge rclk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      occ       <= 2'd0;
      inflight  <= 1'b0;
      burst_cnt <= 8'd0;
      data0     <= '0;
      data1     <= '0;
      last0     <= 1'b0;
      last1     <= 1'b0;
    end else begin
      inflight <= ren;

      case (state)
        IDLE:    if (enable_i) state <= RUN;
        RUN:     if (!enable_i) state <= DRAIN;
        DRAIN: begin
          if (enable_i)                           state <= RUN;
          else if (occ == 2'd0 && !inflight)      state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (pop) begin
        data0 <= data1;
        last0 <= last1;
      end

      // The word requested last cycle is on fifo_dout_i now; later writes override the shift.
      if (inflight) begin
        if (wr_idx == 2'd0) begin
          data0 <= bus.fifo_dout_i;
          last0 <= cap_last;
        end else begin
          data1 <= bus.fifo_dout_i;
          last1 <= cap_last;
        end
        burst_cnt <= cap_last ? 8'd0 : burst_cnt + 8'd1;
      end

      occ <= occ + {1'b0, inflight} - {1'b0, pop};
    end
  end

`ifdef FIFO_RD_STATS_EN
  always_ff @(posedge rclk_i) begin
    if (rst_i) begin
      words_o  <= 32'd0;
      stalls_o <= 32'd0;
    end else begin
      if (pop && words_o != 32'hFFFF_FFFF)
        words_o <= words_o + 32'd1;
      if (bus.m_valid_o && !bus.m_ready_i && stalls_o != 32'hFFFF_FFFF)
        stalls_o <= stalls_o + 32'd1;
    end
  end
`endif

endmodule
